vector_mem_sequencer: RTL and testbench
=======================================

# vector_mem_sequencer

Memory-stage controller that sequences 128-bit vector loads and stores over the 32-bit data-memory port. It sits between the execution/memory pipe register and the external data memory. Scalar accesses pass through in a single cycle. A vector access is split into four word beats at base, base+4, base+8 and base+12; the sequencer holds `stall_mem` high until the last beat.

## Interface
- `N`, 32, scalar word / memory port width
- `V`, 128, vector width; `V/N` = 4 beats
- `ADDR_MAX`, 32'h3D08F, highest legal data-memory address
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `mem_rd_m`  in  1  memory-stage load (memtoreg)
- `mem_wr_m`  in  1  memory-stage store (memw)
- `vect_m`  in  1  memory-stage access is a vector access
- `addr_m`  in  N  base address (ALU result, lane 0)
- `wdata_m`  in  V  store data; lane i = bits [32i+31:32i]
- `mem_rdata`  in  N  word from data memory (combinational read, valid same cycle as `mem_addr`)
- `mem_addr`  out  N  word address to data memory
- `mem_wdata`  out  N  word to data memory
- `mem_we`  out  1  data-memory write enable
- `rdata_m`  out  V  load result to the memory/writeback pipe and forwarding muxes
- `stall_mem`  out  1  holds PC, decode/exe, exe/mem and mem/wb pipes
- `vec_done`  out  1  one-cycle pulse on the final beat of a vector access

## Operation
- FSM states: IDLE and BUSY. Beat counter `beat` is 2 bits. Lane buffer `buf` holds 3 x N bits (lanes 0..2).
- **IDLE, no access** (`mem_rd_m`=`mem_wr_m`=0):
  - `mem_we`=0, `stall_mem`=0, `mem_addr`=`addr_m`, `rdata_m`=0.
- **IDLE, scalar access** (`vect_m`=0):
  - `mem_addr` = `addr_m` (forced to 0 if > `ADDR_MAX`).
  - `mem_we` = `mem_wr_m`, `mem_wdata` = `wdata_m[N-1:0]`.
  - `rdata_m` = {96'b0, `mem_rdata`}.
  - No stall; state stays IDLE.
- **IDLE, vector access**: beat 0 is issued this cycle.
  - `mem_addr` = {`addr_m[N-1:2]`,2'b00}; `mem_we` = `mem_wr_m`; `mem_wdata` = lane 0.
  - `stall_mem`=1.
  - On the clock edge: `buf[0]` <= `mem_rdata`, `beat` <= 1, state <= BUSY.
- **BUSY, beat b** (1..3):
  - `mem_addr` = aligned base + 4b; `mem_wdata` = lane b; `mem_we` = `mem_wr_m`.
  - Base is re-read from `addr_m`, which is stable because the pipe is stalled.
- **BUSY, b = 1 or 2**:
  - `stall_mem`=1; `buf[b]` <= `mem_rdata`; `beat` <= b+1.
- **BUSY, b = 3**:
  - `stall_mem`=0, `vec_done`=1.
  - `rdata_m` = {`mem_rdata`, `buf[2]`, `buf[1]`, `buf[0]`}.
  - Next state IDLE, `beat` <= 0.
- **rdata_m in other cycles**: in BUSY with b < 3, `rdata_m` = 0. Downstream only samples it when the stall is released.
- **Out-of-range beat** (beat address > `ADDR_MAX`): `mem_addr`=0, `mem_we`=0 for that beat, captured lane = 0. The other beats proceed normally.
- **`mem_rd_m` and `mem_wr_m` both high**: the access is treated as a store. `rdata_m` is still assembled, but downstream ignores it.
- **Address arithmetic**: N-bit, wraps modulo 2^N. Wrapped addresses are then subject to the `ADDR_MAX` check.
- **Reset** (`rst`=0, any time including mid-vector): state IDLE, `beat`=0, `buf`=0.
  - While `rst`=0, `mem_we`, `stall_mem` and `vec_done` are forced to 0.
  - An interrupted vector access is abandoned; beats already written are not rolled back.

## Timing
- Scalar access: 0 stall cycles; `rdata_m` valid in the same cycle.
- Vector access: 4 cycles in the memory stage; `stall_mem` high for exactly 3 cycles (beats 0-2).
- Full vector result: valid only in the beat-3 cycle, captured by mem/wb at the following edge.
- Back-to-back vector accesses: the next access starts beat 0 in the cycle after beat 3. There are no idle bubbles.
- Reset values of all outputs:
  - `mem_we`=0, `stall_mem`=0, `vec_done`=0.
  - `rdata_m`=0.
  - `mem_addr`=`addr_m` path, `mem_wdata`=lane-0 path (combinational, no register).

## Structure
- Package `vmem_pkg` holds:
  - state enum {IDLE, BUSY};
  - `WORDS` = V/N;
  - `WORD_STRIDE` = 4;
  - `ADDR_MAX` default.
- Single module, no sub-modules.
- Lane selection and lane-buffer concatenation are written as indexed part-selects driven by `beat`.

## Test plan
- **Scalar load, in range**: `addr_m`=0x100, `mem_rdata`=0xDEADBEEF → same cycle `rdata_m`=0x...0DEADBEEF (zero-extended), `stall_mem`=0.
- **Vector load**: `addr_m`=0x200, memory holds 0x11,0x22,0x33,0x44 at 0x200..0x20C.
  - `mem_addr` sequence 0x200,0x204,0x208,0x20C.
  - `stall_mem` = 1,1,1,0.
  - `rdata_m` in cycle 4 = {0x44,0x33,0x22,0x11}; `vec_done` pulses once.
- **Vector store**: `wdata_m`={0xD,0xC,0xB,0xA}, `addr_m`=0x300 → `mem_we` high 4 cycles, writing 0xA..0xD to 0x300..0x30C in order.
- **Range clip**: vector load at `addr_m`=0x3D088.
  - Beats 0-1 read 0x3D088 and 0x3D08C.
  - Beats 2-3 drive `mem_addr`=0 with `mem_we`=0.
  - Lanes 2-3 of `rdata_m` = 0.
- **Reset mid-vector**: assert `rst`=0 during beat 2 → `stall_mem`=0 and `mem_we`=0 immediately, `buf` is cleared. After release, a new scalar access completes with no stall.
- **Back-to-back**: vector load followed immediately by vector store → 8 consecutive beats, `stall_mem` pattern 1,1,1,0,1,1,1,0.

Source files
------------

// File: rtl/vector_mem_sequencer_pkg.sv
// Shared constants and types for the vector memory sequencer.
// Word-beat geometry and the default data-memory address ceiling.
package vmem_pkg;
    localparam int N           = 32;
    localparam int V           = 128;
    localparam int WORDS       = V / N;
    localparam int WORD_STRIDE = 4;

    localparam logic [N-1:0] ADDR_MAX_DEFAULT = 32'h0003_D08F;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;
endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Memory-stage bundle: pipe-side request/response plus the data-memory port.
// slave is the sequencer view; master is the pipe and memory around it.
interface vmem_if;
    import vmem_pkg::*;

    logic         mem_rd_m;
    logic         mem_wr_m;
    logic         vect_m;
    logic [N-1:0] addr_m;
    logic [V-1:0] wdata_m;
    logic [N-1:0] mem_rdata;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_we;
    logic [V-1:0] rdata_m;
    logic         stall_mem;
    logic         vec_done;

    modport slave (
        input  mem_rd_m, mem_wr_m, vect_m, addr_m, wdata_m, mem_rdata,
        output mem_addr, mem_wdata, mem_we, rdata_m, stall_mem, vec_done
    );

    modport master (
        output mem_rd_m, mem_wr_m, vect_m, addr_m, wdata_m, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, rdata_m, stall_mem, vec_done
    );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Splits 128-bit vector loads/stores into four 32-bit memory beats.
// Scalar accesses pass straight through with no stall.
module vector_mem_sequencer
    import vmem_pkg::*;
#(
    parameter logic [N-1:0] ADDR_MAX = ADDR_MAX_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    vmem_if.slave bus
);
    state_e           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [3*N-1:0]   buf_q, buf_d;

    logic             access;
    logic             busy;
    logic             vec_start;
    logic             last;
    logic [1:0]       beat;
    logic [N-1:0]     base;
    logic [N-1:0]     offs;
    logic [N-1:0]     beat_addr;
    logic             oor;
    logic [N-1:0]     lane;

    always_comb begin
        access    = bus.mem_rd_m | bus.mem_wr_m;
        busy      = state_q == BUSY;
        vec_start = !busy && access && bus.vect_m;
        beat      = busy ? beat_q : 2'd0;
        last      = busy && (beat_q == 2'(WORDS - 1));
        base      = {bus.addr_m[N-1:2], 2'b00};
        offs      = N'(beat) * N'(WORD_STRIDE);
        beat_addr = base + offs;
        oor       = beat_addr > ADDR_MAX;
        lane      = oor ? '0 : bus.mem_rdata;
    end

    always_comb begin
        bus.mem_addr  = bus.addr_m;
        bus.mem_wdata = bus.wdata_m[int'(beat)*N +: N];
        bus.mem_we    = 1'b0;
        bus.stall_mem = 1'b0;
        bus.vec_done  = 1'b0;
        bus.rdata_m   = '0;
        if (busy || vec_start) begin
            bus.mem_addr  = oor ? '0 : beat_addr;
            bus.mem_we    = bus.mem_wr_m && !oor;
            bus.stall_mem = !last;
            bus.vec_done  = last;
            if (last) begin
                bus.rdata_m = {lane, buf_q};
            end
        end else if (access) begin
            bus.mem_addr = (bus.addr_m > ADDR_MAX) ? '0 : bus.addr_m;
            bus.mem_we   = bus.mem_wr_m;
            bus.rdata_m  = {{(V-N){1'b0}}, bus.mem_rdata};
        end
        // reset must silence the pipe and memory even mid-vector
        if (!rst) begin
            bus.mem_we    = 1'b0;
            bus.stall_mem = 1'b0;
            bus.vec_done  = 1'b0;
            bus.rdata_m   = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;
        if (vec_start) begin
            state_d       = BUSY;
            beat_d        = 2'd1;
            buf_d[0 +: N] = lane;
        end else if (busy) begin
            if (last) begin
                state_d = IDLE;
                beat_d  = 2'd0;
            end else begin
                beat_d = beat_q + 2'd1;
                buf_d[int'(beat_q)*N +: N] = lane;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= 2'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
        end
    end
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer: a cycle table plus
// hand-built multi-cycle sequences, each cycle checked on all outputs.
module tb_vector_mem_sequencer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vmem_if bus ();

    vector_mem_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string        nm;
        logic         r;
        logic         rd;
        logic         wr;
        logic         vect;
        logic [31:0]  addr;
        logic [127:0] wd;
        logic [31:0]  mrd;
        logic [31:0]  ea;
        logic [31:0]  ewd;
        logic         ewe;
        logic         est;
        logic         edn;
        logic [127:0] erd;
    } vec_t;

    localparam logic [127:0] WD  = {32'hD, 32'hC, 32'hB, 32'hA};
    localparam logic [127:0] WD2 = {32'h1D, 32'h1C, 32'h1B, 32'h1A};

    vec_t tbl [10];

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string nm, input logic r, input logic rd, input logic wr,
        input logic vect, input logic [31:0] addr, input logic [127:0] wd,
        input logic [31:0] mrd, input logic [31:0] ea, input logic [31:0] ewd,
        input logic ewe, input logic est, input logic edn,
        input logic [127:0] erd
    );
        vec_t v;
        v.nm = nm; v.r = r; v.rd = rd; v.wr = wr; v.vect = vect;
        v.addr = addr; v.wd = wd; v.mrd = mrd; v.ea = ea; v.ewd = ewd;
        v.ewe = ewe; v.est = est; v.edn = edn; v.erd = erd;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld,
                       input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, fld, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst           = v.r;
        bus.mem_rd_m  = v.rd;
        bus.mem_wr_m  = v.wr;
        bus.vect_m    = v.vect;
        bus.addr_m    = v.addr;
        bus.wdata_m   = v.wd;
        bus.mem_rdata = v.mrd;
        #2;
        chk(v.nm, "mem_addr", 128'(bus.mem_addr), 128'(v.ea));
        chk(v.nm, "mem_wdata", 128'(bus.mem_wdata), 128'(v.ewd));
        chk(v.nm, "mem_we", 128'(bus.mem_we), 128'(v.ewe));
        chk(v.nm, "stall_mem", 128'(bus.stall_mem), 128'(v.est));
        chk(v.nm, "vec_done", 128'(bus.vec_done), 128'(v.edn));
        chk(v.nm, "rdata_m", bus.rdata_m, v.erd);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.mem_rd_m = 1'b0;
        bus.mem_wr_m = 1'b0;
        bus.vect_m = 1'b0;
        bus.addr_m = '0;
        bus.wdata_m = '0;
        bus.mem_rdata = '0;
        #1 rst = 1'b0;

        tbl[0] = mk("rst", 0, 1, 1, 1, 32'h100, WD, 32'h55,
                    32'h100, 32'hA, 0, 0, 0, '0);
        tbl[1] = mk("idle", 1, 0, 0, 0, 32'h1234, WD, 32'h77,
                    32'h1234, 32'hA, 0, 0, 0, '0);
        tbl[2] = mk("sld", 1, 1, 0, 0, 32'h100, WD, 32'hDEADBEEF,
                    32'h100, 32'hA, 0, 0, 0, 128'hDEADBEEF);
        tbl[3] = mk("sst", 1, 0, 1, 0, 32'h104, WD, 32'h99,
                    32'h104, 32'hA, 1, 0, 0, 128'h99);
        tbl[4] = mk("sclip", 1, 1, 0, 0, 32'h3D090, WD, 32'h5,
                    32'h0, 32'hA, 0, 0, 0, 128'h5);
        tbl[5] = mk("sedge", 1, 1, 0, 0, 32'h3D08F, WD, 32'h6,
                    32'h3D08F, 32'hA, 0, 0, 0, 128'h6);
        tbl[6] = mk("vld0", 1, 1, 0, 1, 32'h200, WD, 32'h11,
                    32'h200, 32'hA, 0, 1, 0, '0);
        tbl[7] = mk("vld1", 1, 1, 0, 1, 32'h200, WD, 32'h22,
                    32'h204, 32'hB, 0, 1, 0, '0);
        tbl[8] = mk("vld2", 1, 1, 0, 1, 32'h200, WD, 32'h33,
                    32'h208, 32'hC, 0, 1, 0, '0);
        tbl[9] = mk("vld3", 1, 1, 0, 1, 32'h200, WD, 32'h44,
                    32'h20C, 32'hD, 0, 0, 1,
                    {32'h44, 32'h33, 32'h22, 32'h11});

        for (int i = 0; i < 10; i++) apply(tbl[i]);

        // vector store, 4 writes in order
        apply(mk("vst0", 1, 0, 1, 1, 32'h300, WD, 0, 32'h300, 32'hA, 1, 1, 0, '0));
        apply(mk("vst1", 1, 0, 1, 1, 32'h300, WD, 0, 32'h304, 32'hB, 1, 1, 0, '0));
        apply(mk("vst2", 1, 0, 1, 1, 32'h300, WD, 0, 32'h308, 32'hC, 1, 1, 0, '0));
        apply(mk("vst3", 1, 0, 1, 1, 32'h300, WD, 0, 32'h30C, 32'hD, 1, 0, 1, '0));

        // range clip on a vector load
        apply(mk("clp0", 1, 1, 0, 1, 32'h3D088, WD, 1, 32'h3D088, 32'hA, 0, 1, 0, '0));
        apply(mk("clp1", 1, 1, 0, 1, 32'h3D088, WD, 2, 32'h3D08C, 32'hB, 0, 1, 0, '0));
        apply(mk("clp2", 1, 1, 0, 1, 32'h3D088, WD, 3, 32'h0, 32'hC, 0, 1, 0, '0));
        apply(mk("clp3", 1, 1, 0, 1, 32'h3D088, WD, 4, 32'h0, 32'hD, 0, 0, 1,
                 {32'h0, 32'h0, 32'h2, 32'h1}));

        // rd+wr together behaves as a store; clipped beats suppress writes
        apply(mk("cst0", 1, 1, 1, 1, 32'h3D08A, WD, 1, 32'h3D088, 32'hA, 1, 1, 0, '0));
        apply(mk("cst1", 1, 1, 1, 1, 32'h3D08A, WD, 2, 32'h3D08C, 32'hB, 1, 1, 0, '0));
        apply(mk("cst2", 1, 1, 1, 1, 32'h3D08A, WD, 3, 32'h0, 32'hC, 0, 1, 0, '0));
        apply(mk("cst3", 1, 1, 1, 1, 32'h3D08A, WD, 4, 32'h0, 32'hD, 0, 0, 1,
                 {32'h0, 32'h0, 32'h2, 32'h1}));

        // reset during beat 2 of a vector store
        apply(mk("rmv0", 1, 0, 1, 1, 32'h400, WD, 32'hA1, 32'h400, 32'hA, 1, 1, 0, '0));
        apply(mk("rmv1", 1, 0, 1, 1, 32'h400, WD, 32'hA2, 32'h404, 32'hB, 1, 1, 0, '0));
        apply(mk("rmv2", 0, 0, 1, 1, 32'h400, WD, 32'hA3, 32'h400, 32'hA, 0, 0, 0, '0));
        apply(mk("rmvs", 1, 1, 0, 0, 32'h500, WD, 32'h77, 32'h500, 32'hA, 0, 0, 0, 128'h77));

        // back-to-back vector load then vector store
        apply(mk("bl0", 1, 1, 0, 1, 32'h600, WD, 1, 32'h600, 32'hA, 0, 1, 0, '0));
        apply(mk("bl1", 1, 1, 0, 1, 32'h600, WD, 2, 32'h604, 32'hB, 0, 1, 0, '0));
        apply(mk("bl2", 1, 1, 0, 1, 32'h600, WD, 3, 32'h608, 32'hC, 0, 1, 0, '0));
        apply(mk("bl3", 1, 1, 0, 1, 32'h600, WD, 4, 32'h60C, 32'hD, 0, 0, 1,
                 {32'h4, 32'h3, 32'h2, 32'h1}));
        apply(mk("bs0", 1, 0, 1, 1, 32'h703, WD2, 0, 32'h700, 32'h1A, 1, 1, 0, '0));
        apply(mk("bs1", 1, 0, 1, 1, 32'h703, WD2, 0, 32'h704, 32'h1B, 1, 1, 0, '0));
        apply(mk("bs2", 1, 0, 1, 1, 32'h703, WD2, 0, 32'h708, 32'h1C, 1, 1, 0, '0));
        apply(mk("bs3", 1, 0, 1, 1, 32'h703, WD2, 0, 32'h70C, 32'h1D, 1, 0, 1, '0));

        apply(mk("tail", 1, 0, 0, 0, 32'h40, WD, 32'h9, 32'h40, 32'hA, 0, 0, 0, '0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
